// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the instruction/data memory port arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_t;

    // A lone full slot wins outright; on a tie the requester that did not
    // win last time goes next, so neither side can be starved.
    function automatic logic pick_grant(input logic instr_full,
                                        input logic data_full,
                                        input logic last_grant);
        if (instr_full && data_full) begin
            return ~last_grant;
        end
        return data_full ? GRANT_DATA : GRANT_INSTR;
    endfunction

endpackage

// File: rtl/req_slot.sv
// rtl/req_slot.sv - one-entry request holding register with full flag
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load                          capture we/addr/size/wdata and mark full
//   clear                         drop the held request (slot becomes empty)
//   we, addr, size, wdata         incoming request fields
//   full                          slot holds a request
//   slot_we/addr/size/wdata       held request fields
import arb_pkg::*;

module req_slot #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              slot_we,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [1:0]        slot_size,
    output logic [DATA_W-1:0] slot_wdata
);

    // load only happens while empty and clear only while full, so the two
    // never collide; load is still given priority for clarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= 1'b0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_size  <= SIZE_BYTE;
            slot_wdata <= '0;
        end else if (load) begin
            full       <= 1'b1;
            slot_we    <= we;
            slot_addr  <= addr;
            slot_size  <= size;
            slot_wdata <= wdata;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port between fetch and load/store
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   instr_req/addr/size, instr_ready           fetch request handshake
//   instr_rvalid, instr_rdata                  fetch response (one-cycle pulse, data held)
//   data_req/we/addr/size/wdata, data_ready    load/store request handshake
//   data_rvalid, data_rdata                    load/store response (rdata only updated by loads)
//   mem_req/we/addr/size/wdata, mem_rdata      memory port; rdata valid MEM_LAT cycles after mem_req
//   busy                                       an access is in flight
import arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [1:0]        instr_size,
    output logic              instr_ready,
    output logic              instr_rvalid,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ready,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t state, state_nx;
    logic       grant, grant_nx, last_grant;
    logic [3:0] cnt;

    logic              i_full, i_we, d_full, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [1:0]        i_size, d_size;
    logic [DATA_W-1:0] i_wdata, d_wdata;

    assign instr_ready = ~i_full;
    assign data_ready  = ~d_full;
    assign busy        = (state != IDLE);

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_instr_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (instr_req && instr_ready),
        .clear      (state == RESP && grant == GRANT_INSTR),
        .we         (1'b0),
        .addr       (instr_addr),
        .size       (instr_size),
        .wdata      ('0),
        .full       (i_full),
        .slot_we    (i_we),
        .slot_addr  (i_addr),
        .slot_size  (i_size),
        .slot_wdata (i_wdata)
    );

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (data_req && data_ready),
        .clear      (state == RESP && grant == GRANT_DATA),
        .we         (data_we),
        .addr       (data_addr),
        .size       (data_size),
        .wdata      (data_wdata),
        .full       (d_full),
        .slot_we    (d_we),
        .slot_addr  (d_addr),
        .slot_size  (d_size),
        .slot_wdata (d_wdata)
    );

    always_comb begin
        state_nx = state;
        grant_nx = pick_grant(i_full, d_full, last_grant);
        case (state)
            IDLE:    if (i_full || d_full) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // All memory and response outputs are registered: the memory fields are
    // loaded on the IDLE->ISSUE edge so they appear with mem_req and then
    // stay put until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= GRANT_INSTR;
            last_grant   <= GRANT_INSTR;
            cnt          <= 4'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_size     <= SIZE_BYTE;
            mem_wdata    <= '0;
            instr_rvalid <= 1'b0;
            data_rvalid  <= 1'b0;
            instr_rdata  <= '0;
            data_rdata   <= '0;
        end else begin
            state        <= state_nx;
            mem_req      <= 1'b0;
            instr_rvalid <= 1'b0;
            data_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_full || d_full) begin
                        grant     <= grant_nx;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_nx ? d_we    : i_we;
                        mem_addr  <= grant_nx ? d_addr  : i_addr;
                        mem_size  <= grant_nx ? d_size  : i_size;
                        mem_wdata <= grant_nx ? d_wdata : i_wdata;
                    end
                end
                ISSUE: begin
                    last_grant <= grant;
                    cnt        <= 4'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (grant == GRANT_INSTR) begin
                            instr_rdata  <= mem_rdata;
                            instr_rvalid <= 1'b1;
                        end else begin
                            if (!mem_we) data_rdata <= mem_rdata;
                            data_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
    logic [1:0]  instr_size = '0, data_size = '0;
    logic        instr_ready, instr_rvalid, data_ready, data_rvalid;
    logic        mem_req, mem_we, busy;
    logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_size;

    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;

    logic        x_req = 1'b0;
    logic [31:0] x_addr = '0;
    logic        x_ready[2], x_rvalid[2], x_dready[2], x_drvalid[2], x_mreq[2], x_mwe[2], x_busy[2];
    logic [31:0] x_rdata[2], x_drdata[2], x_maddr[2], x_mwdata[2];
    logic [1:0]  x_msize[2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_size(instr_size),
        .instr_ready(instr_ready), .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_size(data_size),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    for (genvar g = 0; g < 2; g++) begin : g_xlat
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 15)) u_x (
            .clk(clk), .rst(rst),
            .instr_req(x_req), .instr_addr(x_addr), .instr_size(2'd2),
            .instr_ready(x_ready[g]), .instr_rvalid(x_rvalid[g]), .instr_rdata(x_rdata[g]),
            .data_req(1'b0), .data_we(1'b0), .data_addr(32'd0), .data_size(2'd0),
            .data_wdata(32'd0), .data_ready(x_dready[g]), .data_rvalid(x_drvalid[g]),
            .data_rdata(x_drdata[g]), .mem_req(x_mreq[g]), .mem_we(x_mwe[g]), .mem_addr(x_maddr[g]),
            .mem_size(x_msize[g]), .mem_wdata(x_mwdata[g]), .mem_rdata(mem_rdata), .busy(x_busy[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        instr_addr = $urandom;
        instr_size = 2'($urandom_range(0, 2));
        data_we    = 1'($urandom_range(0, 1));
        data_addr  = $urandom;
        data_size  = 2'($urandom_range(0, 2));
        data_wdata = $urandom;
    endtask

    // Memory read data changes every cycle so a capture from the wrong cycle shows up.
    initial forever begin
        @(posedge clk);
        #1;
        mem_rdata = force_en ? force_val : $urandom;
    end

    // Transaction-level reference: index 0 = fetch, 1 = data. An access that
    // starts issuing in cycle s owns the port through cycle s+LAT+1, reads
    // memory in cycle s+LAT and responds in cycle s+LAT+1.
    bit          m_valid = 1'b0;
    int          cyc = 0;
    bit [1:0]    m_full = '0;
    logic        m_we[2];
    logic [31:0] m_addr[2], m_wdata[2], m_rd[2];
    logic [1:0]  m_size[2];
    bit          m_act = 1'b0;
    int          m_s = 0, m_g = 0, m_last = 0;
    logic        m_mwe;
    logic [31:0] m_maddr, m_mwdata;
    logic [1:0]  m_msize;

    always @(posedge clk) begin
        bit [1:0] nf;
        int       g;
        nf = m_full;
        if (rst) begin
            m_valid <= 1'b1;
            nf      = '0;
            m_act   <= 1'b0;
            m_last  <= 0;
            m_mwe   <= 1'b0;
            m_maddr <= '0;
            m_msize <= '0;
            m_mwdata <= '0;
            m_rd[0] <= '0;
            m_rd[1] <= '0;
        end else begin
            if (m_act) begin
                if (cyc == m_s + LAT && (m_g == 0 || !m_mwe)) m_rd[m_g] <= mem_rdata;
                if (cyc == m_s + LAT + 1) begin
                    nf[m_g] = 1'b0;
                    m_act <= 1'b0;
                end
            end else if (m_full != 2'b00) begin
                if (m_full == 2'b11) g = 1 - m_last;
                else g = m_full[1] ? 1 : 0;
                m_g      <= g;
                m_last   <= g;
                m_act    <= 1'b1;
                m_s      <= cyc + 1;
                m_mwe    <= m_we[g];
                m_maddr  <= m_addr[g];
                m_msize  <= m_size[g];
                m_mwdata <= m_wdata[g];
            end
            if (instr_req && !m_full[0]) begin
                nf[0] = 1'b1;
                m_we[0] <= 1'b0; m_addr[0] <= instr_addr; m_size[0] <= instr_size; m_wdata[0] <= '0;
            end
            if (data_req && !m_full[1]) begin
                nf[1] = 1'b1;
                m_we[1] <= data_we; m_addr[1] <= data_addr; m_size[1] <= data_size; m_wdata[1] <= data_wdata;
            end
        end
        m_full <= nf;
        cyc    <= cyc + 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("instr_ready", instr_ready, !m_full[0]);
            chk("data_ready", data_ready, !m_full[1]);
            chk("busy", busy, m_act);
            chk("mem_req", mem_req, m_act && cyc == m_s);
            chk("instr_rvalid", instr_rvalid, m_act && m_g == 0 && cyc == m_s + LAT + 1);
            chk("data_rvalid", data_rvalid, m_act && m_g == 1 && cyc == m_s + LAT + 1);
            chk("mem_we", mem_we, m_mwe);
            chk("mem_addr", mem_addr, m_maddr);
            chk("mem_size", mem_size, m_msize);
            chk("mem_wdata", mem_wdata, m_mwdata);
            chk("instr_rdata", instr_rdata, m_rd[0]);
            chk("data_rdata", data_rdata, m_rd[1]);
        end
    end

    initial begin
        int req_k, rv_k, rv_cnt, i_k, d_k, n;
        logic [31:0] got_a, got_d, got_w;
        logic got_we;
        logic [1:0] got_sz;
        int seq[20];
        int xk[2];
        logic [31:0] xd[2];
        logic [31:0] hist[32];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single fetch
        force_en = 1'b1; force_val = 32'hDEAD_BEEF;
        step();
        instr_req = 1'b1; instr_addr = 32'h100; instr_size = 2'd2;
        req_k = -1; rv_k = -1; rv_cnt = 0; got_a = '0; got_we = 1'b1; got_d = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin req_k = k; got_a = mem_addr; got_we = mem_we; end
            if (instr_rvalid) begin rv_k = k; rv_cnt++; got_d = instr_rdata; end
            step();
            instr_req = 1'b0;
        end
        chk("fetch_mem_req_cycle", req_k, 2);
        chk("fetch_rvalid_cycle", rv_k, 5);
        chk("fetch_rvalid_count", rv_cnt, 1);
        chk("fetch_rdata", got_d, 32'hDEAD_BEEF);
        chk("fetch_mem_addr", got_a, 32'h100);
        chk("fetch_mem_we", got_we, 1'b0);

        // simultaneous fetch and load right after reset: data goes first
        rst = 1'b1; step(); step(); rst = 1'b0;
        force_val = 32'hCAFE_F00D;
        step();
        instr_req = 1'b1; instr_addr = 32'h200;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h400; data_size = 2'd2;
        i_k = -1; d_k = -1; rv_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (instr_rvalid) begin i_k = k; rv_cnt++; end
            if (data_rvalid) begin d_k = k; rv_cnt++; end
            step();
            instr_req = 1'b0; data_req = 1'b0;
        end
        chk("tie_data_rvalid_cycle", d_k, 5);
        chk("tie_instr_rvalid_cycle", i_k, 10);
        chk("tie_rvalid_count", rv_cnt, 2);

        // store leaves data_rdata alone
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h10; data_wdata = 32'h1234_5678; data_size = 2'd2;
        rv_k = -1; got_we = 1'b0; got_w = '0; got_a = '0; got_sz = '0; got_d = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_req) begin got_we = mem_we; got_w = mem_wdata; got_a = mem_addr; got_sz = mem_size; end
            if (data_rvalid) begin rv_k = k; got_d = data_rdata; end
            step();
            data_req = 1'b0; data_we = 1'b0;
        end
        chk("store_mem_we", got_we, 1'b1);
        chk("store_mem_wdata", got_w, 32'h1234_5678);
        chk("store_mem_addr", got_a, 32'h10);
        chk("store_mem_size", got_sz, 2'd2);
        chk("store_rvalid_cycle", rv_k, 5);
        chk("store_keeps_data_rdata", got_d, 32'hCAFE_F00D);
        force_en = 1'b0;

        // reset held three cycles while a load is waiting on memory
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h44;
        rv_cnt = 0; req_k = -1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (mem_req && req_k < 0) req_k = k;
            if (k >= 3 && (instr_rvalid || data_rvalid)) rv_cnt++;
            if (k == 5) begin
                chk("rst_mem_req", mem_req, 1'b0);
                chk("rst_instr_ready", instr_ready, 1'b1);
                chk("rst_data_ready", data_ready, 1'b1);
                chk("rst_busy", busy, 1'b0);
            end
            step();
            if (k == 0) data_req = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 6) rst = 1'b0;
        end
        chk("rst_issue_before", req_k, 2);
        chk("rst_no_rvalid", rv_cnt, 0);

        // both requesters saturating: grants alternate starting with data
        step();
        instr_req = 1'b1; data_req = 1'b1; rand_fields();
        n = 0;
        for (int k = 0; k < 400 && n < 20; k++) begin
            @(negedge clk);
            if (data_rvalid && n < 20) begin seq[n] = 1; n++; end
            if (instr_rvalid && n < 20) begin seq[n] = 0; n++; end
            step();
            rand_fields();
        end
        chk("sat_count", n, 20);
        for (int i = 0; i < 20; i++) chk("sat_alternate", seq[i], (i % 2 == 0) ? 1 : 0);
        instr_req = 1'b0; data_req = 1'b0;
        repeat (20) step();

        // random traffic with occasional reset
        for (int k = 0; k < 1500; k++) begin
            step();
            instr_req = ($urandom_range(0, 3) != 0);
            data_req  = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            rand_fields();
        end
        step();
        instr_req = 1'b0; data_req = 1'b0; rst = 1'b0;
        repeat (20) step();

        // MEM_LAT=1 and MEM_LAT=15 builds
        x_req = 1'b1; x_addr = 32'h300;
        xk[0] = -1; xk[1] = -1; xd[0] = '0; xd[1] = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            hist[k] = mem_rdata;
            for (int g = 0; g < 2; g++) if (x_rvalid[g]) begin xk[g] = k; xd[g] = x_rdata[g]; end
            step();
            x_req = 1'b0;
        end
        chk("lat1_rvalid_cycle", xk[0], 4);
        chk("lat15_rvalid_cycle", xk[1], 18);
        chk("lat1_rdata", xd[0], hist[3]);
        chk("lat15_rdata", xd[1], hist[17]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
